// File: rtl/rotate_pipe_if.sv
// Valid/ready bus for rotate_pipe: operand beat in, result beat out.
interface rotate_pipe_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned TAG_W   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_amt;
  logic [1:0]         in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/rotate_pipe.sv
// Pipelined barrel rotator/shifter: one mux level per amount bit, a register after each level.
module rotate_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned TAG_W   = 4
) (
  input logic           clk,
  input logic           rst_n,
  rotate_pipe_if.slave  bus
);

  localparam int unsigned S = SHAMT_W;

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] amt;
    logic [1:0]         op;
    logic [TAG_W-1:0]   tag;
  } stage_t;

  // Amount travels left-aligned: every level tests the MSB, then shifts it out.
  function automatic logic [WIDTH-1:0] move(input logic [WIDTH-1:0] d,
                                            input logic [1:0]       op,
                                            input int unsigned      lg);
    int unsigned m;
    m = 32'd1 << lg;
    case (op)
      2'b00:   move = (d >> m) | (d << (WIDTH - m));
      2'b01:   move = (d << m) | (d >> (WIDTH - m));
      2'b10:   move = d >> m;
      default: move = WIDTH'($signed(d) >>> m);
    endcase
  endfunction

  stage_t             r_stg [S-1];
  logic [WIDTH-1:0]   r_out_data;
  logic [TAG_W-1:0]   r_out_tag;
  logic [S-1:0]       r_vld;
  logic               r_run;

  stage_t             w_lvl_in [S];
  logic [WIDTH-1:0]   w_mov    [S];
  logic [S-1:0]       w_adv;
  logic [S-1:0]       w_load;
  logic [S-1:0]       w_vin;
  logic               w_acc;

  always_comb begin
    w_lvl_in[0] = '{data: bus.in_data, amt: bus.in_amt, op: bus.in_op, tag: bus.in_tag};
    for (int k = 1; k < S; k++) w_lvl_in[k] = r_stg[k-1];
    for (int k = 0; k < S; k++) begin
      w_mov[k] = w_lvl_in[k].data;
      if (w_lvl_in[k].amt[S-1]) w_mov[k] = move(w_lvl_in[k].data, w_lvl_in[k].op, S - 1 - k);
    end
  end

  // A stage advances when the output drains or any stage downstream holds a bubble.
  always_comb begin
    logic bub;
    bub = 1'b0;
    for (int i = S - 1; i >= 0; i--) begin
      w_adv[i]  = r_vld[i] & (bus.out_ready | bub);
      w_load[i] = ~r_vld[i] | w_adv[i];
      bub       = bub | ~r_vld[i];
    end
  end

  assign bus.in_ready = r_run & w_load[0];
  assign w_acc        = bus.in_valid & bus.in_ready;
  assign w_vin        = {r_vld[S-2:0], w_acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_vld      <= '0;
      r_out_data <= '0;
      r_out_tag  <= '0;
      for (int i = 0; i < S - 1; i++) r_stg[i] <= '0;
    end else begin
      r_run <= 1'b1;
      for (int i = 0; i < S; i++) begin
        if (w_load[i]) r_vld[i] <= w_vin[i];
      end
      for (int i = 0; i < S - 1; i++) begin
        if (w_load[i] && w_vin[i]) begin
          r_stg[i] <= '{data: w_mov[i],
                        amt:  w_lvl_in[i].amt << 1,
                        op:   w_lvl_in[i].op,
                        tag:  w_lvl_in[i].tag};
        end
      end
      if (w_load[S-1] && w_vin[S-1]) begin
        r_out_data <= w_mov[S-1];
        r_out_tag  <= w_lvl_in[S-1].tag;
      end
    end
  end

  assign bus.out_valid = r_vld[S-1];
  assign bus.out_data  = r_out_data;
  assign bus.out_tag   = r_out_tag;

endmodule

// File: tb/tb_rotate_pipe.sv
// Scoreboarded bench for rotate_pipe: directed vectors, random burst, backpressure and reset.
module tb_rotate_pipe;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  exp_t q[$];

  rotate_pipe_if #(.WIDTH(32), .SHAMT_W(5), .TAG_W(4)) bus ();

  rotate_pipe #(.WIDTH(32), .SHAMT_W(5), .TAG_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int ND = 15;
  logic [31:0] dv_d [ND] = '{32'h00000001, 32'h12345678, 32'h12345678, 32'h80000000,
                             32'hF0000000, 32'hF0000000, 32'h70000000, 32'hDEADBEEF,
                             32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000001,
                             32'h00000001, 32'h80000000, 32'h80000000};
  logic [4:0]  dv_a [ND] = '{5'd1, 5'd16, 5'd8, 5'd4, 5'd4, 5'd4, 5'd4,
                             5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31, 5'd31};
  logic [1:0]  dv_o [ND] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3,
                             2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2};
  logic [31:0] dv_e [ND] = '{32'h80000000, 32'h56781234, 32'h78123456, 32'h00000008,
                             32'h0F000000, 32'hFF000000, 32'h07000000, 32'hDEADBEEF,
                             32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000002,
                             32'h80000000, 32'hFFFFFFFF, 32'h00000001};

  function automatic logic [31:0] ref_model(input logic [31:0] d, input logic [4:0] a,
                                            input logic [1:0] op);
    logic [63:0] dd;
    logic [63:0] tmp;
    dd = {d, d};
    case (op)
      2'd0:    begin tmp = dd >> a; ref_model = tmp[31:0];  end
      2'd1:    begin tmp = dd << a; ref_model = tmp[63:32]; end
      2'd2:    ref_model = d >> a;
      default: ref_model = $unsigned($signed(d) >>> a);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every transferred result is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_out++;
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got data %h tag %h, expected nothing", bus.out_data, bus.out_tag);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.out_data !== e.d || bus.out_tag !== e.t) begin
          n_err++;
          $display("FAIL result: got data %h tag %h expected data %h tag %h",
                   bus.out_data, bus.out_tag, e.d, e.t);
        end
      end
    end
  end

  task automatic set_beat(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                          input logic [3:0] t);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_op    = op;
    bus.in_tag   = t;
  endtask

  // Present one beat from posedge+1, push its expectation once accepted.
  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                      input logic [3:0] t, input logic [31:0] e, output int waits);
    set_beat(d, a, op, t);
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 100) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: got no in_ready, required in_ready=1");
        break;
      end
    end
    if (bus.in_ready) q.push_back('{e, t});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic latency(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.out_valid || n >= 50) break;
    end
    chk(name, 32'(n), 32'd5);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int w;
    int acc;
    int j;
    logic got;
    logic have;
    logic [31:0] snap;
    logic [31:0] rd;
    logic [4:0]  ra;
    logic [1:0]  ro;
    int out_before;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_out_tag",   32'(bus.out_tag),   32'd0);
    repeat (2) @(posedge clk);
    release_reset();

    // Directed vectors, each with a latency check on an empty pipe.
    for (int i = 0; i < ND; i++) begin
      send(dv_d[i], dv_a[i], dv_o[i], 4'(i), dv_e[i], w);
      latency("latency_directed");
      wait_drain();
      @(posedge clk); #1;
    end

    // Back-to-back random burst with no bubbles.
    for (int i = 0; i < 100; i++) begin
      rd = $urandom;
      ra = 5'($urandom_range(0, 31));
      ro = 2'($urandom_range(0, 3));
      send(rd, ra, ro, 4'(i), ref_model(rd, ra, ro), w);
      chk("burst_no_bubble", 32'(w), 32'd0);
    end
    wait_drain();
    @(posedge clk); #1;

    // Backpressure: fill with out_ready low, then release.
    bus.out_ready = 1'b0;
    acc  = 0;
    j    = 0;
    have = 1'b0;
    snap = '0;
    set_beat(32'hA5000000 | 32'(j), 5'(j + 1), 2'd1, 4'(j + 8));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      got = bus.in_ready;
      if (got) begin
        q.push_back('{ref_model(bus.in_data, bus.in_amt, bus.in_op), bus.in_tag});
        acc++;
      end
      if (bus.out_valid && !have) begin
        snap = bus.out_data;
        have = 1'b1;
      end
      @(posedge clk); #1;
      if (got) begin
        j++;
        set_beat(32'hA5000000 | 32'(j), 5'(j + 1), 2'd1, 4'(j + 8));
      end
    end
    @(negedge clk);
    chk("stall_accepted",  32'(acc),           32'd5);
    chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_out_data",  bus.out_data,       snap);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();
    @(posedge clk); #1;

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) send(32'h0000F00D, 5'(i + 3), 2'd0, 4'(i + 3),
                                     ref_model(32'h0000F00D, 5'(i + 3), 2'd0), w);
    rst_n = 1'b0;
    #1;
    chk("inflight_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("inflight_rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("inflight_rst_out_data",  bus.out_data,       32'd0);
    q.delete();
    out_before = n_out;
    repeat (2) @(posedge clk);
    release_reset();
    repeat (8) @(posedge clk);
    #1;
    chk("no_ghost_beats", 32'(n_out - out_before), 32'd0);
    send(32'h12345678, 5'd4, 2'd1, 4'hC, 32'h23456781, w);
    latency("latency_after_reset");
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rotate_pipe.md
ROTATE_PIPE -- requirements
Module: rotate_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a power of two, 8..64.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), shift-amount width; SHALL equal log2(WIDTH).
REQ-003 Parameter TAG_W, default 4, width of the sideband tag carried alongside the data.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts the beat this cycle.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_amt  input  SHAMT_W  shift/rotate amount, 0..WIDTH-1.
REQ-010 in_op  input  2  operation: 00 ROTR, 01 ROTL, 10 SHR (logical), 11 SRA (arithmetic).
REQ-011 in_tag  input  TAG_W  sideband, returned unchanged with the result.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_data  output  WIDTH  result.
REQ-015 out_tag  output  TAG_W  tag of the result.

Function
REQ-016 Datapath: SHAMT_W mux levels; level k (k=0 first) SHALL apply a move of 2^(SHAMT_W-1-k) bits when amount bit SHAMT_W-1-k is set, otherwise pass through.
REQ-017 A pipeline register (data, remaining amount, op, tag, valid) SHALL follow every level; latency from accepted input to out_valid SHALL be exactly SHAMT_W cycles (5 at WIDTH=32).
REQ-018 ROTR: bits leaving the LSB end re-enter at the MSB end.
REQ-019 ROTL: bits leaving the MSB end re-enter at the LSB end; ROTL by n SHALL equal ROTR by (WIDTH-n) mod WIDTH.
REQ-020 SHR: vacated MSBs filled with 0.
REQ-021 SRA: vacated MSBs filled with the operand's original bit WIDTH-1.
REQ-022 in_amt=0 SHALL return in_data unchanged for all ops.
REQ-023 Handshake: a beat transfers when valid and ready are both high at a clock edge; in_ready and out_ready SHALL be valid/ready-compliant (valid, once high, holds data stable until accepted).
REQ-024 Stage i SHALL load when it is empty or its contents move to stage i+1 (or out, for the last stage) in the same cycle; otherwise it holds.
REQ-025 in_ready SHALL be high when stage 0 is empty or stage 0 advances this cycle; in_ready SHALL NOT depend combinationally on in_valid.
REQ-026 With out_ready held high, the block SHALL accept one beat per cycle with no bubbles.
REQ-027 With out_ready low, the pipeline SHALL fill to SHAMT_W beats, then drop in_ready; no beat SHALL be lost, duplicated or reordered.
REQ-028 Simultaneous accept on input and drain on output when full SHALL be allowed (in_ready high when the whole chain advances).
REQ-029 out_data and out_tag SHALL be registered outputs held stable while out_valid is high and out_ready is low.
REQ-030 Results SHALL emerge in acceptance order with their own tag.

Reset
REQ-031 rst_n low SHALL asynchronously clear all stage valid bits; out_valid=0, out_data=0, out_tag=0, in_ready=0 while reset is asserted.
REQ-032 Beats in flight when reset asserts SHALL be discarded; in_ready SHALL rise on the first clock edge after rst_n deasserts.

Verification
REQ-033 ROTR 0x00000001 amt 1 -> 0x80000000; ROTR 0x12345678 amt 16 -> 0x56781234; ROTR 0x12345678 amt 8 -> 0x78123456, each after 5 cycles.
REQ-034 ROTL 0x80000000 amt 4 -> 0x00000008; SHR 0xF0000000 amt 4 -> 0x0F000000; SRA 0xF0000000 amt 4 -> 0xFF000000; SRA 0x70000000 amt 4 -> 0x07000000.
REQ-035 amt 0 with each op on 0xDEADBEEF -> 0xDEADBEEF; amt 31 ROTR 0x00000001 -> 0x00000002.
REQ-036 100 back-to-back random beats, out_ready=1 -> one result per cycle, match a reference model, tags in order.
REQ-037 out_ready low for 10 cycles while in_valid high -> exactly 5 beats accepted, in_ready low, out_data stable; release -> all drain in order.
REQ-038 rst_n pulsed low with 3 beats in flight -> out_valid drops immediately, none of the 3 emerge; next beat after reset returns correct result at latency 5.
